// File: rtl/flow_block_mux.sv
// flow_block_mux: two-flow block multiplexer.
//
// Each flow buffers pixels in its own DEPTH-entry FIFO. A grant FSM serves one
// flow at a time in blocks of len[f] elements and only changes the grant at a
// block boundary. Emitted pixels are tagged with the flow id in the MSB and
// delivered through a registered output stage.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-low reset
//   cfg_write  - configuration strobe
//   cfg_din    - [7] flow id, [6:0] block length
//   inF_din    - flow F pixel            (F = 0, 1)
//   inF_write  - flow F write strobe
//   inF_full   - flow F FIFO full
//   out_din    - tagged pixel {flow id, data}
//   out_write  - out_din valid this cycle
//   out_full   - per-flow downstream full, bit f stalls flow f
//   blk_cnt0/1 - completed-block counters (only with FLOW_BLOCK_MUX_STATS_EN)
//
// Build option: define FLOW_BLOCK_MUX_STATS_EN to add the block counters.
module flow_block_mux #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_write,
    input  logic [7:0]    cfg_din,
    input  logic [DW-1:0] in0_din,
    input  logic          in0_write,
    output logic          in0_full,
    input  logic [DW-1:0] in1_din,
    input  logic          in1_write,
    output logic          in1_full,
    output logic [DW:0]   out_din,
    output logic          out_write,
    input  logic [1:0]    out_full
`ifdef FLOW_BLOCK_MUX_STATS_EN
    ,
    output logic [15:0]   blk_cnt0,
    output logic [15:0]   blk_cnt1
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFOs
    // ------------------------------------------------------------------
    logic [DW-1:0] in_din [2];
    logic [1:0]    in_write;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    fifo_full;

    logic [DW-1:0] mem_q [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] wr_ptr_d [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [AW-1:0] rd_ptr_d [2];
    logic [CW-1:0] fifo_cnt_q [2];
    logic [CW-1:0] fifo_cnt_d [2];

    // ------------------------------------------------------------------
    // Grant FSM, block lengths and output stage
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [6:0]    elem_cnt_q, elem_cnt_d;
    logic [6:0]    elem_inc;
    logic [6:0]    len_q [2];
    logic [6:0]    len_d [2];
    logic [6:0]    pend_q [2];
    logic [6:0]    pend_d [2];
    logic [1:0]    pend_vld_q, pend_vld_d;
    logic [DW:0]   out_din_q, out_din_d;
    logic          out_write_q, out_write_d;

    logic          active;
    logic          cur;
    logic          oth;
    logic          emit;
    logic          blk_end;
    logic          cfg_f;
    logic [6:0]    cfg_len;
    logic          cfg_mid_block;
    logic [6:0]    new_len;
    logic [DW-1:0] rd_data;

    assign in_din[0]   = in0_din;
    assign in_din[1]   = in1_din;
    assign in_write[0] = in0_write;
    assign in_write[1] = in1_write;

    assign fifo_full[0] = (fifo_cnt_q[0] == CW'(DEPTH));
    assign fifo_full[1] = (fifo_cnt_q[1] == CW'(DEPTH));
    assign in0_full     = fifo_full[0];
    assign in1_full     = fifo_full[1];

    assign out_din   = out_din_q;
    assign out_write = out_write_q;

    // Grant decode and emission qualification.
    always_comb begin
        active   = (state_q != StIdle);
        cur      = (state_q == StGrant1);
        oth      = ~cur;
        rd_data  = mem_q[cur][rd_ptr_q[cur]];
        elem_inc = elem_cnt_q + 7'd1;
        // A zero length while granted can only follow an unconfigure at a
        // boundary; nothing is emitted then and the FSM moves on.
        emit     = active && (len_q[cur] != 7'd0) && (fifo_cnt_q[cur] != '0)
                   && !out_full[cur];
        blk_end  = emit && (elem_inc == len_q[cur]);

        cfg_f         = cfg_din[7];
        cfg_len       = cfg_din[6:0];
        cfg_mid_block = active && (cfg_f == cur) && (len_q[cur] != 7'd0);
        // Length that takes effect for the current flow at its boundary.
        if (cfg_write && (cfg_f == cur)) begin
            new_len = cfg_len;
        end else if (pend_vld_q[cur]) begin
            new_len = pend_q[cur];
        end else begin
            new_len = len_q[cur];
        end
    end

    // FIFO pointer and occupancy update. A push at full is dropped while a
    // simultaneous pop still proceeds.
    always_comb begin
        for (int f = 0; f < 2; f++) begin
            push[f]       = in_write[f] & ~fifo_full[f];
            pop[f]        = emit & (cur == 1'(f));
            wr_ptr_d[f]   = wr_ptr_q[f] + AW'(push[f]);
            rd_ptr_d[f]   = rd_ptr_q[f] + AW'(pop[f]);
            fifo_cnt_d[f] = fifo_cnt_q[f] + CW'(push[f]) - CW'(pop[f]);
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int f = 0; f < 2; f++) begin
            if (push[f]) begin
                mem_q[f][wr_ptr_q[f]] <= in_din[f];
            end
        end
    end

    // Block length bookkeeping. A write for the flow in the middle of its
    // block is parked as pending; otherwise it applies at the next edge.
    always_comb begin
        for (int f = 0; f < 2; f++) begin
            len_d[f]  = len_q[f];
            pend_d[f] = pend_q[f];
        end
        pend_vld_d = pend_vld_q;

        if (cfg_write) begin
            pend_d[cfg_f] = cfg_len;
            if (cfg_mid_block) begin
                pend_vld_d[cfg_f] = 1'b1;
            end else begin
                len_d[cfg_f]      = cfg_len;
                pend_vld_d[cfg_f] = 1'b0;
            end
        end

        if (blk_end) begin
            len_d[cur]      = new_len;
            pend_vld_d[cur] = 1'b0;
        end
    end

    // Grant FSM next state and element counter.
    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;

        unique case (state_q)
            StIdle: begin
                elem_cnt_d = 7'd0;
                if (len_q[0] != 7'd0) begin
                    state_d = StGrant0;
                end else if (len_q[1] != 7'd0) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (len_q[cur] == 7'd0) begin
                    elem_cnt_d = 7'd0;
                    if (len_q[oth] != 7'd0) begin
                        state_d = oth ? StGrant1 : StGrant0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (emit) begin
                    if (blk_end) begin
                        elem_cnt_d = 7'd0;
                        if ((len_q[oth] != 7'd0) && (fifo_cnt_q[oth] != '0)) begin
                            state_d = oth ? StGrant1 : StGrant0;
                        end else if ((new_len == 7'd0) && (len_q[oth] == 7'd0)) begin
                            state_d = StIdle;
                        end
                    end else begin
                        elem_cnt_d = elem_inc;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                elem_cnt_d = 7'd0;
            end
        endcase
    end

    // Output register: loads on emission, otherwise holds data and drops valid.
    always_comb begin
        out_din_d   = out_din_q;
        out_write_d = 1'b0;
        if (emit) begin
            out_din_d   = {cur, rd_data};
            out_write_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < 2; f++) begin
                wr_ptr_q[f]   <= '0;
                rd_ptr_q[f]   <= '0;
                fifo_cnt_q[f] <= '0;
                len_q[f]      <= 7'd0;
                pend_q[f]     <= 7'd0;
            end
            pend_vld_q  <= 2'b00;
            state_q     <= StIdle;
            elem_cnt_q  <= 7'd0;
            out_din_q   <= '0;
            out_write_q <= 1'b0;
        end else begin
            for (int f = 0; f < 2; f++) begin
                wr_ptr_q[f]   <= wr_ptr_d[f];
                rd_ptr_q[f]   <= rd_ptr_d[f];
                fifo_cnt_q[f] <= fifo_cnt_d[f];
                len_q[f]      <= len_d[f];
                pend_q[f]     <= pend_d[f];
            end
            pend_vld_q  <= pend_vld_d;
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            out_din_q   <= out_din_d;
            out_write_q <= out_write_d;
        end
    end

`ifdef FLOW_BLOCK_MUX_STATS_EN
    // Completed-block counters, wrapping at 16 bits.
    logic [15:0] blk_cnt_q [2];
    logic [15:0] blk_cnt_d [2];

    always_comb begin
        for (int f = 0; f < 2; f++) begin
            blk_cnt_d[f] = blk_cnt_q[f];
        end
        if (blk_end) begin
            blk_cnt_d[cur] = blk_cnt_q[cur] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < 2; f++) begin
                blk_cnt_q[f] <= 16'd0;
            end
        end else begin
            for (int f = 0; f < 2; f++) begin
                blk_cnt_q[f] <= blk_cnt_d[f];
            end
        end
    end

    assign blk_cnt0 = blk_cnt_q[0];
    assign blk_cnt1 = blk_cnt_q[1];
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_flow_block_mux.sv
// Directed testbench for flow_block_mux with hand-computed expected beats.
module tb_flow_block_mux;

    logic       clk;
    logic       rst;
    logic       cfg_write;
    logic [7:0] cfg_din;
    logic [7:0] in0_din;
    logic       in0_write;
    logic       in0_full;
    logic [7:0] in1_din;
    logic       in1_write;
    logic       in1_full;
    logic [8:0] out_din;
    logic       out_write;
    logic [1:0] out_full;
`ifdef FLOW_BLOCK_MUX_STATS_EN
    logic [15:0] blk_cnt0;
    logic [15:0] blk_cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] beats [$];

    flow_block_mux #(
        .DW    (8),
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_write (cfg_write),
        .cfg_din   (cfg_din),
        .in0_din   (in0_din),
        .in0_write (in0_write),
        .in0_full  (in0_full),
        .in1_din   (in1_din),
        .in1_write (in1_write),
        .in1_full  (in1_full),
        .out_din   (out_din),
        .out_write (out_write),
        .out_full  (out_full)
`ifdef FLOW_BLOCK_MUX_STATS_EN
        ,
        .blk_cnt0  (blk_cnt0),
        .blk_cnt1  (blk_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every emitted beat away from the active edge.
    always @(negedge clk) begin
        if (rst && out_write) beats.push_back(out_din);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        cfg_write = 1'b0;
        cfg_din   = 8'h00;
        in0_write = 1'b0;
        in0_din   = 8'h00;
        in1_write = 1'b0;
        in1_din   = 8'h00;
        out_full  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        beats.delete();
    endtask

    task automatic cfg(input logic [7:0] word);
        cfg_write = 1'b1;
        cfg_din   = word;
        tick();
        cfg_write = 1'b0;
    endtask

    // Compare the recorded beats against an expected list.
    task automatic check_beats(input string tag, input logic [8:0] exp [$]);
        check({tag, " count"}, beats.size(), exp.size());
        for (int i = 0; i < exp.size() && i < beats.size(); i++) begin
            check($sformatf("%s beat %0d", tag, i), {23'd0, beats[i]}, {23'd0, exp[i]});
        end
    endtask

    initial begin
        logic [8:0] exp [$];
        int n0, n1;
        bit w0, w1, cfg_done;

        // ---------------- reset state ----------------
        do_reset();
        check("rst in0_full", in0_full, 0);
        check("rst in1_full", in1_full, 0);
        check("rst out_write", out_write, 0);
        check("rst out_din", out_din, 0);

        // ---------------- full boundary ----------------
        for (int i = 0; i < 16; i++) begin
            in0_write = 1'b1;
            in0_din   = 8'(i);
            tick();
            if (i == 14) check("full after 15", in0_full, 0);
            if (i == 15) check("full after 16", in0_full, 1);
        end
        in0_din = 8'hEE;
        tick();
        check("full 17th dropped", in0_full, 1);
        check("no grant unconfigured", out_write, 0);
        in0_din = 8'h99;
        cfg(8'h17);
        check("cfg edge no emit", out_write, 0);
        tick();
        check("idle exit no emit", out_write, 0);
        check("full before pop", in0_full, 1);
        tick();
        in0_write = 1'b0;
        check("push+pop full cleared", in0_full, 0);
        check("push+pop out_write", out_write, 1);
        check("push+pop out_din", out_din, 9'h000);
        repeat (25) tick();
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back({1'b0, 8'(i)});
        check_beats("full drain", exp);

        // ---------------- single flow ----------------
        do_reset();
        cfg(8'h17);
        for (int i = 0; i < 23; i++) begin
            in0_write = 1'b1;
            in0_din   = 8'h40 + 8'(i);
            tick();
        end
        in0_write = 1'b0;
        repeat (30) tick();
        exp.delete();
        for (int i = 0; i < 23; i++) exp.push_back({1'b0, 8'h40 + 8'(i)});
        check_beats("single", exp);
        // Still granted flow 0 with counter 0: next pixel emerges one edge later.
        in0_write = 1'b1;
        in0_din   = 8'h77;
        tick();
        in0_write = 1'b0;
        check("latency early", out_write, 0);
        tick();
        check("latency out_write", out_write, 1);
        check("latency out_din", out_din, 9'h077);

        // ---------------- back-pressure ----------------
        do_reset();
        out_full = 2'b01;
        cfg(8'h04);
        cfg(8'h84);
        for (int i = 0; i < 4; i++) begin
            in0_write = 1'b1;
            in0_din   = 8'h10 + 8'(i);
            in1_write = 1'b1;
            in1_din   = 8'h20 + 8'(i);
            tick();
        end
        in0_write = 1'b0;
        in1_write = 1'b0;
        repeat (6) tick();
        check("bp out_write", out_write, 0);
        check("bp no beats", beats.size(), 0);
        out_full = 2'b00;
        repeat (20) tick();
        exp.delete();
        for (int i = 0; i < 4; i++) exp.push_back({1'b0, 8'h10 + 8'(i)});
        for (int i = 0; i < 4; i++) exp.push_back({1'b1, 8'h20 + 8'(i)});
        check_beats("bp", exp);

        // ---------------- boundary with other flow empty ----------------
        do_reset();
        cfg(8'h02);
        cfg(8'h82);
        for (int i = 0; i < 4; i++) begin
            in0_write = 1'b1;
            in0_din   = 8'h30 + 8'(i);
            tick();
        end
        in0_write = 1'b0;
        repeat (12) tick();
        exp.delete();
        for (int i = 0; i < 4; i++) exp.push_back({1'b0, 8'h30 + 8'(i)});
        check_beats("stay", exp);

        // ---------------- interleaving ----------------
        do_reset();
        cfg(8'h17);
        cfg(8'h97);
        n0 = 0;
        n1 = 0;
        for (int cyc = 0; cyc < 4000 && beats.size() < 1058; cyc++) begin
            w0 = (n0 < 529) && !in0_full;
            w1 = (n1 < 529) && !in1_full;
            in0_write = w0;
            in0_din   = 8'(n0);
            in1_write = w1;
            in1_din   = 8'(n1);
            tick();
            if (w0) n0++;
            if (w1) n1++;
        end
        in0_write = 1'b0;
        in1_write = 1'b0;
        repeat (3) tick();
        check("ilv flow0 written", n0, 529);
        check("ilv flow1 written", n1, 529);
        exp.delete();
        for (int k = 0; k < 1058; k++) begin
            int blk, idx;
            blk = k / 23;
            idx = (blk / 2) * 23 + (k % 23);
            exp.push_back({1'(blk % 2), 8'(idx)});
        end
        check_beats("ilv", exp);

        // ---------------- length change mid-block ----------------
        do_reset();
        cfg(8'h17);
        cfg(8'h81);
        n0 = 0;
        n1 = 0;
        cfg_done = 1'b0;
        for (int cyc = 0; cyc < 300 && beats.size() < 33; cyc++) begin
            w0 = (n0 < 60) && !in0_full;
            w1 = (n1 < 10) && !in1_full;
            in0_write = w0;
            in0_din   = 8'(n0);
            in1_write = w1;
            in1_din   = 8'h80 + 8'(n1);
            if (!cfg_done && beats.size() == 5) begin
                cfg_write = 1'b1;
                cfg_din   = 8'h04;
                cfg_done  = 1'b1;
            end else begin
                cfg_write = 1'b0;
            end
            tick();
            if (w0) n0++;
            if (w1) n1++;
        end
        cfg_write = 1'b0;
        in0_write = 1'b0;
        in1_write = 1'b0;
        exp.delete();
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 23; i++) begin exp.push_back({1'b0, 8'(n0)}); n0++; end
        exp.push_back({1'b1, 8'h80 + 8'(n1)}); n1++;
        for (int i = 0; i < 4; i++) begin exp.push_back({1'b0, 8'(n0)}); n0++; end
        exp.push_back({1'b1, 8'h80 + 8'(n1)}); n1++;
        for (int i = 0; i < 4; i++) begin exp.push_back({1'b0, 8'(n0)}); n0++; end
        for (int i = 0; i < 33 && i < beats.size(); i++) begin
            check($sformatf("relen beat %0d", i), {23'd0, beats[i]}, {23'd0, exp[i]});
        end
        check("relen reached 33", beats.size() >= 33, 1);

        // ---------------- reset mid-block ----------------
        do_reset();
        cfg(8'h17);
        for (int i = 0; i < 8; i++) begin
            in0_write = 1'b1;
            in0_din   = 8'h51 + 8'(i);
            in1_write = 1'b1;
            in1_din   = 8'h60 + 8'(i);
            tick();
        end
        check("pre-rst out_write", out_write, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid rst out_write", out_write, 0);
        check("mid rst out_din", out_din, 0);
        check("mid rst in0_full", in0_full, 0);
        check("mid rst in1_full", in1_full, 0);
        in0_write = 1'b0;
        in1_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        beats.delete();
        for (int i = 0; i < 2; i++) begin
            in1_write = 1'b1;
            in1_din   = 8'hB0 + 8'(i);
            tick();
        end
        in1_write = 1'b0;
        repeat (8) tick();
        check("post rst silent", beats.size(), 0);
        cfg(8'h85);
        repeat (10) tick();
        exp.delete();
        exp.push_back(9'h1B0);
        exp.push_back(9'h1B1);
        check_beats("post rst", exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flow_block_mux.md
FLOW_BLOCK_MUX -- requirements
Module: flow_block_mux

Interface
REQ-001 Parameter DW, default 8, pixel data width per flow.
REQ-002 Parameter DEPTH, default 16, per-flow input FIFO depth in elements (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low: asserted when 0, released synchronously to clk by the environment.
REQ-005 cfg_write  input  1  configuration strobe.
REQ-006 cfg_din  input  8  configuration word: [7] is the flow id, [6:0] is the block length (elements per grant).
REQ-007 in0_din  input  DW  flow-0 pixel.
REQ-008 in0_write  input  1  flow-0 write strobe.
REQ-009 in0_full  output  1  flow-0 FIFO full.
REQ-010 in1_din, in1_write, in1_full: same as REQ-007 to REQ-009, for flow 1.
REQ-011 out_din  output  DW+1  tagged pixel: [DW] is the flow id, [DW-1:0] is the data.
REQ-012 out_write  output  1  out_din is valid this cycle.
REQ-013 out_full  input  2  per-flow downstream full: bit f blocks emission of flow f.

Function
REQ-014 Input FIFOs
- Each flow SHALL have a DEPTH-entry FIFO.
- A write is accepted when inF_write=1 and inF_full=0.
- A write made while full SHALL be dropped, with no state change.
REQ-015 Full flag: inF_full SHALL be 1 exactly when the FIFO count equals DEPTH; count is registered.
- Push and pop in the same cycle at full: the push is dropped and the pop proceeds.
REQ-016 Block lengths
- Each flow has a registered block length len[f], reset 0.
- A flow with len[f]=0 is unconfigured and SHALL never be granted.
REQ-017 Length update timing
- cfg_write loads a pending length for flow cfg_din[7].
- The pending length becomes len[f] at the next block boundary of f, or immediately if f is not currently granted.
REQ-018 FSM states: IDLE, GRANT0, GRANT1.
- IDLE -> GRANTf when len[f]!=0; flow 0 wins a tie.
- Leaving IDLE resets the element counter to 0.
REQ-019 Emission
- In GRANTf, one element SHALL be emitted per cycle when FIFO f is non-empty and out_full[f]=0.
- Each emission increments the element counter.
REQ-020 Output register
- The emission pops FIFO f and loads out_din={f, data} with out_write=1 at the same clock edge.
- Otherwise out_write SHALL be 0 after that edge and out_din SHALL hold its value.
REQ-021 Latency: a write accepted at edge t SHALL be visible on out_write no earlier than edge t+1, when the flow is granted and its FIFO is empty.
REQ-022 Block boundary: the emission that makes counter = len[f] ends the block.
- The counter resets to 0.
- The grant moves to flow 1-f if len[1-f]!=0 and FIFO 1-f is non-empty.
- Otherwise the grant stays on f.
- If len[f] has become 0 and 1-f is unconfigured, the FSM goes to IDLE.
REQ-023 No mid-block switching: the grant SHALL NOT change inside a block, whatever the FIFO or out_full state.
REQ-024 Counter width: the element counter is 7 bits and SHALL never exceed len[f].

Reset
REQ-025 On rst=0, asynchronously:
- FIFOs empty, in0_full=in1_full=0.
- len and pending lengths 0.
- FSM in IDLE, counter 0.
- out_write=0, out_din=0.
REQ-026 Reset asserted mid-block SHALL discard all buffered data. After release, no output appears until reconfiguration.

Configuration
REQ-027 Macro FLOW_BLOCK_MUX_STATS_EN.
- Defined: adds outputs blk_cnt0 and blk_cnt1 (16 bits each, reset 0). Each increments once per completed block of its flow and wraps at 0xFFFF -> 0.
- Undefined: these ports and their logic SHALL be absent. All other behaviour is identical.

Verification
REQ-028 Single flow: cfg 0x17 (flow 0, len 23), write 23 pixels to flow 0 -> 23 out_write beats tagged 0, data in order, FSM back in GRANT0.
REQ-029 Interleaving: both flows len 23, both FIFOs kept fed -> bursts alternate 23x tag 0, then 23x tag 1, and so on; 529 elements per flow, none lost or reordered.
REQ-030 Back-pressure: out_full=2'b01 during a flow-0 block -> no emission and grant stays flow 0 (no switch to flow 1); resumes when cleared.
REQ-031 Full boundary: 17 writes to flow 0 with no grant -> in0_full=1 after the 16th, 17th dropped; same-cycle push+pop at full -> count 15.
REQ-032 Boundary with other flow empty: at flow-0 block end with flow-1 FIFO empty -> grant stays flow 0.
REQ-033 Mid-operation changes:
- Reset mid-block -> outputs 0 and FIFOs empty.
- cfg to len 4 mid-block of 23 -> the current block completes at 23, the next block is 4.
